// File: rtl/xif_issue_responder.sv
// rtl/xif_issue_responder.sv - CV-X-IF issue responder with in-order commit/kill queue
module xif_issue_responder #(
  parameter int DEPTH = 4,
  parameter int ID_W  = 3,
  parameter int XLEN  = 64
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            issue_valid_i,
  output logic            issue_ready_o,
  input  logic [31:0]     issue_instr_i,
  input  logic [ID_W-1:0] issue_id_i,
  input  logic [XLEN-1:0] issue_rs0_i,
  input  logic [XLEN-1:0] issue_rs1_i,
  input  logic [1:0]      issue_rs_valid_i,
  output logic            issue_accept_o,
  output logic            issue_writeback_o,
  input  logic            commit_valid_i,
  input  logic [ID_W-1:0] commit_id_i,
  input  logic            commit_kill_i,
  input  logic            flush_i,
  output logic            exec_valid_o,
  input  logic            exec_ready_i,
  output logic [31:0]     exec_instr_o,
  output logic [ID_W-1:0] exec_id_o,
  output logic [XLEN-1:0] exec_rs0_o,
  output logic [XLEN-1:0] exec_rs1_o,
  output logic            exec_wb_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [31:0]      instr_q [DEPTH];
  logic [ID_W-1:0]  id_q    [DEPTH];
  logic [XLEN-1:0]  rs0_q   [DEPTH];
  logic [XLEN-1:0]  rs1_q   [DEPTH];
  logic [DEPTH-1:0] wb_q;
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] cmt_q;
  logic [DEPTH-1:0] kill_q;
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [CNT_W-1:0] count_q;

  logic             is_c0;
  logic             is_c1;
  logic             dec_accept;
  logic             dec_wb;
  logic             full;
  logic             push;
  logic             pop;
  logic             head_live;
  logic             bypass;
  logic [DEPTH-1:0] match;

  assign is_c0      = (issue_instr_i[6:0] == 7'b0001011);
  assign is_c1      = (issue_instr_i[6:0] == 7'b0101011);
  assign dec_accept = is_c0 || is_c1;
  assign dec_wb     = is_c0 && (issue_instr_i[11:7] != 5'd0);
  assign full       = (count_q == FULL_CNT);

  // Rejected opcodes are always acknowledged so the core never stalls on them.
  assign issue_ready_o     = !rst_i && !flush_i &&
                             (!dec_accept || (!full && issue_rs_valid_i == 2'b11));
  assign issue_accept_o    = issue_valid_i && dec_accept;
  assign issue_writeback_o = issue_valid_i && dec_wb;
  assign push              = issue_valid_i && issue_ready_o && dec_accept;

  // Masking with reset/flush keeps a discarded head from looking like a handshake.
  assign head_live    = valid_q[head_q] && !rst_i && !flush_i;
  assign exec_valid_o = head_live && cmt_q[head_q];
  assign pop          = head_live && (kill_q[head_q] || (cmt_q[head_q] && exec_ready_i));

  assign exec_instr_o = instr_q[head_q];
  assign exec_id_o    = id_q[head_q];
  assign exec_rs0_o   = rs0_q[head_q];
  assign exec_rs1_o   = rs1_q[head_q];
  assign exec_wb_o    = wb_q[head_q];

  always_comb begin
    match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match[i] = commit_valid_i && valid_q[i] && !cmt_q[i] && !kill_q[i] &&
                 (id_q[i] == commit_id_i);
    end
  end

  // A commit naming the instruction being issued this cycle lands on the new entry.
  assign bypass = commit_valid_i && (issue_id_i == commit_id_i);

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      valid_q <= '0;
      cmt_q   <= '0;
      kill_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (match[i]) begin
          if (commit_kill_i) kill_q[i] <= 1'b1;
          else               cmt_q[i]  <= 1'b1;
        end
      end
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PTR_W'(1);
      end
      if (push) begin
        valid_q[tail_q] <= 1'b1;
        cmt_q[tail_q]   <= bypass && !commit_kill_i;
        kill_q[tail_q]  <= bypass && commit_kill_i;
        tail_q          <= tail_q + PTR_W'(1);
      end
      if (push && !pop)      count_q <= count_q + CNT_W'(1);
      else if (pop && !push) count_q <= count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      instr_q[tail_q] <= issue_instr_i;
      id_q[tail_q]    <= issue_id_i;
      rs0_q[tail_q]   <= issue_rs0_i;
      rs1_q[tail_q]   <= issue_rs1_i;
      wb_q[tail_q]    <= dec_wb;
    end
  end

endmodule
